imm_encoder: RTL and testbench
==============================

// Module: imm_encoder
// PURPOSE
// Inverse of the decode-stage immediate extender: packs a 32-bit immediate into the RISC-V
// instruction fields selected by ImmSrc and merges it with a base instruction word.
// Two-stage valid/ready pipeline with range/alignment checking.
// Feeds the self-test program generator that writes instruction memory.
// Round trip: Extend(InstrOut[31:7], ImmSrc) == ImmIn for every accepted, error-free word.
// PARAMETERS
// ERR_W   8   width of saturating error counter ErrCount
// PORTS
// clock     in   1   system clock, rising edge
// reset     in   1   synchronous, active-high
// InValid   in   1   input word present
// InReady   out  1   block can accept input this cycle
// BaseInstr in   32  opcode/rd/funct3/rs1/rs2/funct7 bits; immediate-field bits ignored
// ImmIn     in   32  immediate value to encode
// ImmSrc    in   3   0=I 1=S 2=B 3=J 4=U 5..7=invalid
// OutValid  out  1   InstrOut valid
// OutReady  in   1   consumer accepts InstrOut
// InstrOut  out  32  encoded instruction
// ImmErr    out  1   qualifies InstrOut: immediate not representable or ImmSrc invalid
// ErrCount  out  ERR_W  count of accepted words flagged ImmErr, saturates at all-ones
// BEHAVIOUR
// - Reset (sync, high): S1/S2 valid=0, OutValid=0, InstrOut=0, ImmErr=0, ErrCount=0.
//   Reset mid-stream drops both in-flight words; InReady=1 in the cycle after reset.
// - Handshake: transfer on Valid&&Ready. OutValid is not withdrawn, and InstrOut/ImmErr
//   do not change, until OutReady.
// - Advance rules:
//   s2_adv = !s2_valid || OutReady
//   s1_adv = !s1_valid || s2_adv
//   InReady = s1_adv (combinational, no skid)
//   Full throughput: one word/cycle when OutReady is held high.
// - Latency: word accepted at edge N appears with OutValid=1 after edge N+1, i.e. two edges.
// - S1 registers: BaseInstr, ImmIn and ImmSrc, plus
//   err1 = ImmSrc invalid OR range/alignment check failed.
// - S2 registers InstrOut = merge(BaseInstr, packed imm) and ImmErr = err1.
// - Packing: bits not listed for a format come from BaseInstr.
//   I: [31:20]=imm[11:0]; legal if imm in [-2048, 2047]
//   S: [31:25]=imm[11:5], [11:7]=imm[4:0]; range as I
//   B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]
//      legal if imm[0]==0 and imm in [-4096, 4094]
//   J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]
//      legal if imm[0]==0 and imm in [-2^20, 2^20-2]
//   U: [31:12]=imm[31:12]; legal if imm[11:0]==0
//   Range test: the bits above the field's sign bit must equal that sign bit.
// - Error words: still packed (truncated fields) and still emitted with ImmErr=1.
//   Invalid ImmSrc: InstrOut=BaseInstr unchanged.
// - ErrCount: +1 at the S2 load of an errored word; holds at 2^ERR_W-1.
// - Simultaneous S1 load and S2 drain in the same cycle is legal; no bubble is inserted.
// TESTING
// - Reset, then I-type: Base=32'h00000013, Imm=32'hFFFFF800, Src=0
//   -> InstrOut=32'h80000013, ImmErr=0, two edges after accept.
// - B-type: Base=32'h00000063, Imm=32'h00000FFE, Src=2
//   -> InstrOut=32'h7E000FE3, ImmErr=0.
//   Same with Imm=1 -> ImmErr=1, ErrCount=1.
// - Round trip: 1000 random legal (Imm,Src) pairs through imm_encoder then Extend
//   -> ImmExtD==ImmIn every time.
// - Backpressure: OutReady=0 for 5 cycles with 3 words offered
//   -> 2 accepted, InReady=0, InstrOut stable; release -> words in order, none lost or duplicated.
// - Edge cases:
//   U-type Imm=32'h12345000 -> InstrOut[31:12]=20'h12345
//   U-type Imm=32'h12345001 -> ImmErr=1
//   Src=6 -> ImmErr=1, InstrOut=Base
// - Reset asserted with both stages full -> next cycle OutValid=0, ErrCount=0, InReady=1;
//   ERR_W=2 with 5 errors -> ErrCount=3.

Source files
------------

// File: rtl/imm_encoder_if.sv
// Valid/ready bundle between the instruction producer, imm_encoder and its consumer.
interface imm_encoder_if #(
    parameter int ERR_W = 8
);
    logic             InValid;
    logic             InReady;
    logic [31:0]      BaseInstr;
    logic [31:0]      ImmIn;
    logic [2:0]       ImmSrc;
    logic             OutValid;
    logic             OutReady;
    logic [31:0]      InstrOut;
    logic             ImmErr;
    logic [ERR_W-1:0] ErrCount;

    modport master (
        output InValid, BaseInstr, ImmIn, ImmSrc, OutReady,
        input  InReady, OutValid, InstrOut, ImmErr, ErrCount
    );
    modport slave (
        input  InValid, BaseInstr, ImmIn, ImmSrc, OutReady,
        output InReady, OutValid, InstrOut, ImmErr, ErrCount
    );
endinterface

// File: rtl/imm_encoder.sv
// Packs a 32-bit immediate into the RISC-V I/S/B/J/U fields of a base instruction.
// Two-stage valid/ready pipeline: S1 captures and range-checks, S2 merges and holds output.
module imm_encoder #(
    parameter int ERR_W = 8
) (
    input logic          clock,
    input logic          reset,
    imm_encoder_if.slave bus
);
    localparam logic [2:0] SRC_I = 3'd0;
    localparam logic [2:0] SRC_S = 3'd1;
    localparam logic [2:0] SRC_B = 3'd2;
    localparam logic [2:0] SRC_J = 3'd3;
    localparam logic [2:0] SRC_U = 3'd4;

    logic             s1_valid_q, s1_valid_d;
    logic [31:0]      s1_base_q, s1_base_d;
    logic [31:0]      s1_imm_q, s1_imm_d;
    logic [2:0]       s1_src_q, s1_src_d;
    logic             s1_err_q, s1_err_d;
    logic             s2_valid_q, s2_valid_d;
    logic [31:0]      instr_q, instr_d;
    logic             err_q, err_d;
    logic [ERR_W-1:0] cnt_q, cnt_d;

    logic        s1_adv, s2_adv;
    logic        in_err;
    logic [31:0] packed_instr;

    assign s2_adv = !s2_valid_q || bus.OutReady;
    assign s1_adv = !s1_valid_q || s2_adv;

    // Representable when every bit above the field's sign bit copies it.
    always_comb begin
        in_err = 1'b0;
        case (bus.ImmSrc)
            SRC_I, SRC_S: in_err = (bus.ImmIn[31:11] != {21{bus.ImmIn[11]}});
            SRC_B:        in_err = bus.ImmIn[0] || (bus.ImmIn[31:12] != {20{bus.ImmIn[12]}});
            SRC_J:        in_err = bus.ImmIn[0] || (bus.ImmIn[31:20] != {12{bus.ImmIn[20]}});
            SRC_U:        in_err = (bus.ImmIn[11:0] != 12'd0);
            default:      in_err = 1'b1;
        endcase
    end

    always_comb begin
        packed_instr = s1_base_q;
        case (s1_src_q)
            SRC_I: packed_instr[31:20] = s1_imm_q[11:0];
            SRC_S: begin
                packed_instr[31:25] = s1_imm_q[11:5];
                packed_instr[11:7]  = s1_imm_q[4:0];
            end
            SRC_B: begin
                packed_instr[31]    = s1_imm_q[12];
                packed_instr[30:25] = s1_imm_q[10:5];
                packed_instr[11:8]  = s1_imm_q[4:1];
                packed_instr[7]     = s1_imm_q[11];
            end
            SRC_J: begin
                packed_instr[31]    = s1_imm_q[20];
                packed_instr[30:21] = s1_imm_q[10:1];
                packed_instr[20]    = s1_imm_q[11];
                packed_instr[19:12] = s1_imm_q[19:12];
            end
            SRC_U:   packed_instr[31:12] = s1_imm_q[31:12];
            default: packed_instr = s1_base_q;
        endcase
    end

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path infers a latch.
        s1_valid_d = s1_valid_q;
        s1_base_d  = s1_base_q;
        s1_imm_d   = s1_imm_q;
        s1_src_d   = s1_src_q;
        s1_err_d   = s1_err_q;
        s2_valid_d = s2_valid_q;
        instr_d    = instr_q;
        err_d      = err_q;
        cnt_d      = cnt_q;

        if (s1_adv) begin
            s1_valid_d = bus.InValid;
            if (bus.InValid) begin
                s1_base_d = bus.BaseInstr;
                s1_imm_d  = bus.ImmIn;
                s1_src_d  = bus.ImmSrc;
                s1_err_d  = in_err;
            end
        end

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                instr_d = packed_instr;
                err_d   = s1_err_q;
                if (s1_err_q && (cnt_q != '1)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: state uses non-blocking assignment so every register samples pre-edge values.
        if (reset) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            instr_q    <= '0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            instr_q    <= instr_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    // NOTE: S1 payload is qualified by s1_valid_q, so it needs no reset.
    always_ff @(posedge clock) begin
        s1_base_q <= s1_base_d;
        s1_imm_q  <= s1_imm_d;
        s1_src_q  <= s1_src_d;
        s1_err_q  <= s1_err_d;
    end

    assign bus.InReady  = s1_adv;
    assign bus.OutValid = s2_valid_q;
    assign bus.InstrOut = instr_q;
    assign bus.ImmErr   = err_q;
    assign bus.ErrCount = cnt_q;
endmodule

// File: tb/tb_imm_encoder.sv
// Directed and round-trip bench for imm_encoder, plus a narrow-counter instance for saturation.
module tb_imm_encoder;
    localparam int RT_N = 1000;

    typedef struct {
        logic [31:0] imm;
        logic [2:0]  src;
    } rt_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    imm_encoder_if #(.ERR_W(8)) bus ();
    imm_encoder_if #(.ERR_W(2)) bus2 ();

    imm_encoder #(.ERR_W(8)) dut  (.clock(clock), .reset(reset), .bus(bus));
    imm_encoder #(.ERR_W(2)) dut2 (.clock(clock), .reset(reset), .bus(bus2));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Decode-stage immediate extender: the inverse the encoder must satisfy.
    function automatic logic [31:0] extend(input logic [31:0] i, input logic [2:0] src);
        case (src)
            3'd0:    return {{20{i[31]}}, i[31:20]};
            3'd1:    return {{20{i[31]}}, i[31:25], i[11:7]};
            3'd2:    return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
            3'd3:    return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
            default: return {i[31:12], 12'd0};
        endcase
    endfunction

    task automatic gen_legal(output logic [31:0] imm, output logic [2:0] src);
        logic [31:0] r;
        r   = $urandom;
        src = 3'($urandom_range(0, 4));
        case (src)
            3'd0, 3'd1: imm = {{20{r[11]}}, r[11:0]};
            3'd2:       imm = {{19{r[12]}}, r[12:1], 1'b0};
            3'd3:       imm = {{11{r[20]}}, r[20:1], 1'b0};
            default:    imm = {r[31:12], 12'd0};
        endcase
    endtask

    // One word through an empty pipeline with OutReady held high; called #1 after an edge.
    task automatic run_one(input string tag, input logic [31:0] base, input logic [31:0] imm,
                           input logic [2:0] src, input logic [31:0] exp_instr,
                           input logic exp_err, input logic [31:0] exp_cnt);
        bus.BaseInstr = base;
        bus.ImmIn     = imm;
        bus.ImmSrc    = src;
        bus.InValid   = 1'b1;
        @(negedge clock);
        check({tag, "/in_ready"}, bus.InReady, 1);
        @(posedge clock); #1;
        bus.InValid = 1'b0;
        check({tag, "/latency"}, bus.OutValid, 0);
        @(posedge clock); #1;
        check({tag, "/out_valid"}, bus.OutValid, 1);
        check({tag, "/instr"}, bus.InstrOut, exp_instr);
        check({tag, "/err"}, bus.ImmErr, exp_err);
        check({tag, "/err_count"}, bus.ErrCount, exp_cnt);
        @(posedge clock); #1;
    endtask

    initial begin
        rt_t         rt_q[$];
        rt_t         e;
        logic [31:0] exp_q[$];
        logic [31:0] bp_exp [3];
        logic [31:0] imm;
        logic [2:0]  src;
        logic        pending;
        int          sent, got, cyc, idx, n_out;

        bus.InValid    = 1'b0;
        bus.BaseInstr  = '0;
        bus.ImmIn      = '0;
        bus.ImmSrc     = '0;
        bus.OutReady   = 1'b1;
        bus2.InValid   = 1'b0;
        bus2.BaseInstr = '0;
        bus2.ImmIn     = '0;
        bus2.ImmSrc    = '0;
        bus2.OutReady  = 1'b1;
        reset          = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        check("reset/out_valid", bus.OutValid, 0);
        check("reset/in_ready", bus.InReady, 1);
        check("reset/instr", bus.InstrOut, 0);
        check("reset/err", bus.ImmErr, 0);
        check("reset/err_count", bus.ErrCount, 0);

        run_one("i_min",   32'h00000013, 32'hFFFFF800, 3'd0, 32'h80000013, 1'b0, 0);
        run_one("i_base",  32'hABC00013, 32'h000007FF, 3'd0, 32'h7FF00013, 1'b0, 0);
        run_one("b_max",   32'h00000063, 32'h00000FFE, 3'd2, 32'h7E000FE3, 1'b0, 0);
        run_one("b_odd",   32'h00000063, 32'h00000001, 3'd2, 32'h00000063, 1'b1, 1);
        run_one("u_ok",    32'h00000037, 32'h12345000, 3'd4, 32'h12345037, 1'b0, 1);
        run_one("u_low",   32'h00000037, 32'h12345001, 3'd4, 32'h12345037, 1'b1, 2);
        run_one("src6",    32'h12345678, 32'h00000004, 3'd6, 32'h12345678, 1'b1, 3);
        run_one("s_neg",   32'h00002023, 32'hFFFFFFFC, 3'd1, 32'hFE002E23, 1'b0, 3);
        run_one("i_range", 32'h00000013, 32'h00000800, 3'd0, 32'h80000013, 1'b1, 4);
        run_one("j_2048",  32'h0000006F, 32'h00000800, 3'd3, 32'h0010006F, 1'b0, 4);
        run_one("j_odd",   32'h0000006F, 32'h00000003, 3'd3, 32'h0020006F, 1'b1, 5);

        // Round trip at full throughput.
        pending = 1'b0;
        sent = 0; got = 0; cyc = 0;
        while (got < RT_N && cyc < 20000) begin
            if (!pending && sent < RT_N) begin
                gen_legal(imm, src);
                bus.BaseInstr = $urandom;
                bus.ImmIn     = imm;
                bus.ImmSrc    = src;
                pending       = 1'b1;
            end
            bus.InValid = pending;
            @(negedge clock);
            if (bus.OutValid && bus.OutReady) begin
                if (rt_q.size() > 0) begin
                    e = rt_q.pop_front();
                    check("rt/extend", extend(bus.InstrOut, e.src), e.imm);
                    check("rt/err", bus.ImmErr, 0);
                end
                got++;
            end
            if (bus.InValid && bus.InReady) begin
                rt_q.push_back('{imm: bus.ImmIn, src: bus.ImmSrc});
                sent++;
                pending = 1'b0;
            end
            @(posedge clock); #1;
            cyc++;
        end
        bus.InValid = 1'b0;
        check("rt/count", got, RT_N);
        check("rt/throughput", cyc, RT_N + 2);
        repeat (2) @(posedge clock);
        #1;

        // Backpressure: consumer stalled for 5 cycles while 3 words are offered.
        bp_exp = '{32'h00100013, 32'h00200013, 32'h00300013};
        bus.OutReady  = 1'b0;
        bus.BaseInstr = 32'h00000013;
        bus.ImmSrc    = 3'd0;
        idx = 0;
        bus.ImmIn   = 32'(idx + 1);
        bus.InValid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            if (bus.InValid && bus.InReady) begin
                exp_q.push_back(bp_exp[idx]);
                idx++;
            end
            if (c >= 2) check("bp/hold", bus.InstrOut, bp_exp[0]);
            @(posedge clock); #1;
            bus.ImmIn   = 32'(idx + 1);
            bus.InValid = (idx < 3);
        end
        check("bp/accepted", idx, 2);
        check("bp/in_ready", bus.InReady, 0);
        check("bp/out_valid", bus.OutValid, 1);
        bus.OutReady = 1'b1;
        n_out = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            if (bus.OutValid && bus.OutReady) begin
                if (exp_q.size() > 0) check("bp/order", bus.InstrOut, exp_q.pop_front());
                n_out++;
            end
            if (bus.InValid && bus.InReady) begin
                exp_q.push_back(bp_exp[idx]);
                idx++;
            end
            @(posedge clock); #1;
            bus.ImmIn   = 32'(idx + 1);
            bus.InValid = (idx < 3);
        end
        check("bp/out_count", n_out, 3);
        check("bp/leftover", exp_q.size(), 0);

        // Reset with both stages holding errored words.
        bus.OutReady  = 1'b0;
        bus.BaseInstr = 32'hDEADBEEF;
        bus.ImmSrc    = 3'd7;
        bus.InValid   = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        check("rst_full/out_valid_pre", bus.OutValid, 1);
        check("rst_full/in_ready_pre", bus.InReady, 0);
        check("rst_full/err_count_pre", bus.ErrCount, 6);
        reset       = 1'b1;
        bus.InValid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        check("rst_full/out_valid", bus.OutValid, 0);
        check("rst_full/err_count", bus.ErrCount, 0);
        check("rst_full/in_ready", bus.InReady, 1);
        check("rst_full/instr", bus.InstrOut, 0);
        bus.OutReady = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("rst_full/no_ghost", bus.OutValid, 0);

        // Saturation of a 2-bit error counter with 5 errored words.
        bus2.ImmSrc  = 3'd5;
        bus2.InValid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clock); #1;
            if (c == 2) check("sat/err_count_mid", bus2.ErrCount, 2);
        end
        bus2.InValid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("sat/err_count", bus2.ErrCount, 3);
        check("sat/err", bus2.ImmErr, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
